// File: rtl/rle_pkg.sv
// Shared types and constants for the binary-mask RLE decoder.
// RLE_DEC_COLOUR_EN switches pixels from 1-bit mask values to 24-bit colour.
package rle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    PAD  = 2'd2
  } rle_state_e;

  // Run word layout on the link: value bit above a length-minus-one field.
  localparam int RLE_LEN_W = 10;
  typedef struct packed {
    logic                 value;
    logic [RLE_LEN_W-1:0] len;
  } rle_run_t;

  localparam logic [23:0] RLE_COLOUR_ON  = {8'hFF, 8'h00, 8'h00};
  localparam logic [23:0] RLE_COLOUR_OFF = 24'h00_0000;

`ifdef RLE_DEC_COLOUR_EN
  localparam int RLE_PIX_W = 24;
`else
  localparam int RLE_PIX_W = 1;
`endif

  function automatic logic [RLE_PIX_W-1:0] rle_pixel(input logic value);
`ifdef RLE_DEC_COLOUR_EN
    return value ? RLE_COLOUR_ON : RLE_COLOUR_OFF;
`else
    return value;
`endif
  endfunction

endpackage

// File: rtl/rle_run_decoder_if.sv
// Run-word input channel and pixel output channel of the RLE decoder.
// The decoder takes the slave view; the run source / pixel sink take the master view.
interface rle_run_decoder_if #(
  parameter int LEN_W = rle_pkg::RLE_LEN_W,
  parameter int PIX_W = rle_pkg::RLE_PIX_W
);
  logic             in_valid;
  logic             in_ready;
  logic             in_value;
  logic [LEN_W-1:0] in_len;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_sop;
  logic             out_eol;
  logic             out_eop;

  modport slave (
    input  in_valid, in_value, in_len, in_sof, out_ready,
    output in_ready, out_valid, out_pixel, out_sop, out_eol, out_eop
  );

  modport master (
    output in_valid, in_value, in_len, in_sof, out_ready,
    input  in_ready, out_valid, out_pixel, out_sop, out_eol, out_eop
  );
endinterface

// File: rtl/rle_raster_counter.sv
// Raster position counter: x wraps at WIDTH-1 into y, y wraps at HEIGHT-1.
// Reports first-pixel, end-of-line and end-of-frame for the current position.
module rle_raster_counter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic clear_i,
  input  logic advance_i,
  output logic sop_o,
  output logic eol_o,
  output logic eop_o
);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  assign sop_o = (x_q == '0) && (y_q == '0);
  assign eol_o = (x_q == XW'(WIDTH - 1));
  assign eop_o = eol_o && (y_q == YW'(HEIGHT - 1));

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (eol_o) begin
        x_d = '0;
        y_d = eop_o ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    // NOTE: registers take non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/rle_run_decoder.sv
// Expands run-length words into a WIDTHxHEIGHT raster pixel stream with sop/eol/eop,
// truncating over-long frames and zero-padding short ones. Optional: RLE_DEC_COLOUR_EN.
module rle_run_decoder
  import rle_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int LEN_W  = RLE_LEN_W
) (
  input  logic               CLK,
  input  logic               reset_n,
  rle_run_decoder_if.slave   s,
  output logic               err_overrun,
  output logic               err_underrun,
  output logic               frame_done
);

  rle_state_e       state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             value_q, value_d;
  logic             in_frame_q, in_frame_d;

  logic in_ready;
  logic out_valid;
  logic run_last;
  logic clear, advance;
  logic pos_sop, pos_eol, pos_eop;

  rle_raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .clear_i   (clear),
    .advance_i (advance),
    .sop_o     (pos_sop),
    .eol_o     (pos_eol),
    .eop_o     (pos_eop)
  );

  assign run_last  = (remaining_q == '0);
  assign out_valid = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    value_d      = value_q;
    in_frame_d   = in_frame_q;
    in_ready     = 1'b0;
    clear        = 1'b0;
    advance      = 1'b0;
    err_overrun  = 1'b0;
    err_underrun = 1'b0;
    frame_done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A new frame cannot start while the previous one still needs padding.
        in_ready = !(in_frame_q && s.in_sof);
        if (s.in_valid) begin
          if (s.in_sof && in_frame_q) begin
            err_underrun = 1'b1;
            state_d      = PAD;
          end else if (s.in_sof) begin
            remaining_d = s.in_len;
            value_d     = s.in_value;
            in_frame_d  = 1'b1;
            clear       = 1'b1;
            state_d     = EMIT;
          end else if (!in_frame_q) begin
            err_overrun = 1'b1;
          end else begin
            remaining_d = s.in_len;
            value_d     = s.in_value;
            state_d     = EMIT;
          end
        end
      end

      EMIT: begin
        // Chaining the next run on the last pixel keeps the stream bubble-free.
        if (run_last) in_ready = s.out_ready && !pos_eop && !s.in_sof;
        if (s.out_ready) begin
          advance = 1'b1;
          if (pos_eop) begin
            err_overrun = !run_last;
            frame_done  = 1'b1;
            in_frame_d  = 1'b0;
            state_d     = IDLE;
          end else if (!run_last) begin
            remaining_d = remaining_q - 1'b1;
          end else if (s.in_valid && !s.in_sof) begin
            remaining_d = s.in_len;
            value_d     = s.in_value;
          end else if (s.in_valid) begin
            err_underrun = 1'b1;
            state_d      = PAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      PAD: begin
        if (s.out_ready) begin
          advance = 1'b1;
          if (pos_eop) begin
            frame_done = 1'b1;
            in_frame_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      value_q     <= 1'b0;
      in_frame_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      value_q     <= value_d;
      in_frame_q  <= in_frame_d;
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid;
  assign s.out_pixel = rle_pixel((state_q == EMIT) && value_q);
  assign s.out_sop   = out_valid && pos_sop;
  assign s.out_eol   = out_valid && pos_eol;
  assign s.out_eop   = out_valid && pos_eop;

endmodule

// File: tb/tb_rle_run_decoder.sv
// Directed bench for rle_run_decoder on a 4x2 raster: normal frame, backpressure,
// overrun truncation, underrun padding, stray run and mid-frame reset.
module tb_rle_run_decoder;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int LW = 10;

  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  logic err_overrun, err_underrun, frame_done;
  logic bp_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] pix_q[$];
  logic [4:0]  mk_q[$];
  int          cyc_q[$];
  int          n_ovr = 0;
  int          n_und = 0;
  int          n_fd  = 0;

  rle_run_decoder_if #(.LEN_W(LW)) bus ();

  rle_run_decoder #(
    .WIDTH  (W),
    .HEIGHT (H),
    .LEN_W  (LW)
  ) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .s            (bus),
    .err_overrun  (err_overrun),
    .err_underrun (err_underrun),
    .frame_done   (frame_done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_pixel(input logic v);
`ifdef RLE_DEC_COLOUR_EN
    return v ? 32'h00FF_0000 : 32'h0;
`else
    return {31'd0, v};
`endif
  endfunction

  // Pixel sink: out_ready pattern is 1 normally, alternating 1/0 under bp_en.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      bus.out_ready = bp_en ? ~bus.out_ready : 1'b1;
    end
  end

  // Monitor: records handshaken pixels, counts pulses, checks stall stability.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_pix;
    logic [2:0]  prev_mk;
    prev_stall = 1'b0;
    prev_pix   = '0;
    prev_mk    = '0;
    forever begin
      @(negedge CLK);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
          check("stall_pixel", 32'(bus.out_pixel), prev_pix);
          check("stall_marks", {29'd0, bus.out_sop, bus.out_eol, bus.out_eop}, {29'd0, prev_mk});
        end
        if (bus.out_valid && !bus.out_ready)
          check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_pix   = 32'(bus.out_pixel);
        prev_mk    = {bus.out_sop, bus.out_eol, bus.out_eop};
        if (bus.out_valid && bus.out_ready) begin
          pix_q.push_back(32'(bus.out_pixel));
          mk_q.push_back({bus.out_sop, bus.out_eol, bus.out_eop, frame_done, err_overrun});
          cyc_q.push_back(cyc);
        end
        n_ovr += int'(err_overrun);
        n_und += int'(err_underrun);
        n_fd  += int'(frame_done);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send_run(input logic sof, input logic val, input logic [LW-1:0] len);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_value = val;
    bus.in_len   = len;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge CLK);
      acc = bus.in_ready;
      @(posedge CLK);
      #1;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Compares one 8-pixel frame starting at queue index base; pix bit i is pixel i.
  task automatic check_frame(input string tag, input int base, input logic [7:0] pix,
                             input logic ovr_at_eop);
    logic [4:0] emk;
    check($sformatf("%s_enough", tag), {31'd0, pix_q.size() >= base + 8}, 32'd1);
    if (pix_q.size() < base + 8) return;
    for (int i = 0; i < 8; i++) begin
      emk = {i == 0, (i % W) == W - 1, i == 7, i == 7, ovr_at_eop && (i == 7)};
      check($sformatf("%s_px%0d", tag, i), pix_q[base + i], exp_pixel(pix[i]));
      check($sformatf("%s_mk%0d", tag, i), {27'd0, mk_q[base + i]}, {27'd0, emk});
    end
  endtask

  initial begin
    int b, o0, u0, f0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_value = 1'b0;
    bus.in_len   = '0;

    repeat (3) @(posedge CLK);
    #1 reset_n = 1'b1;
    @(negedge CLK);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check("rst_markers",   {29'd0, bus.out_sop, bus.out_eol, bus.out_eop}, 32'd0);
    check("rst_pixel",     32'(bus.out_pixel), 32'd0);
    check("rst_pulses",    {29'd0, err_overrun, err_underrun, frame_done}, 32'd0);
    @(posedge CLK);
    #1;

    // Basic frame: 1,1,1 then 0 x5, back-to-back.
    b = pix_q.size(); o0 = n_ovr; u0 = n_und; f0 = n_fd;
    send_run(1'b1, 1'b1, 10'd2);
    send_run(1'b0, 1'b0, 10'd4);
    idle_in();
    wait_cycles(12);
    check("basic_count", pix_q.size() - b, 32'd8);
    check_frame("basic", b, 8'h07, 1'b0);
    if (pix_q.size() >= b + 8)
      check("basic_gapless", cyc_q[b + 7] - cyc_q[b], 32'd7);
    check("basic_frame_done", n_fd - f0, 32'd1);
    check("basic_errors", (n_ovr - o0) + (n_und - u0), 32'd0);

    // Backpressure: same frame with out_ready alternating.
    b = pix_q.size(); f0 = n_fd;
    bp_en = 1'b1;
    send_run(1'b1, 1'b1, 10'd2);
    send_run(1'b0, 1'b0, 10'd4);
    idle_in();
    wait_cycles(24);
    bp_en = 1'b0;
    wait_cycles(2);
    check("bp_count", pix_q.size() - b, 32'd8);
    check_frame("bp", b, 8'h07, 1'b0);
    check("bp_frame_done", n_fd - f0, 32'd1);

    // Overrun: a 12-pixel run is cut at eop.
    b = pix_q.size(); o0 = n_ovr; f0 = n_fd;
    send_run(1'b1, 1'b1, 10'd11);
    idle_in();
    wait_cycles(12);
    check("ovr_count", pix_q.size() - b, 32'd8);
    check_frame("ovr", b, 8'hFF, 1'b1);
    check("ovr_pulses", n_ovr - o0, 32'd1);
    check("ovr_frame_done", n_fd - f0, 32'd1);
    @(negedge CLK);
    check("ovr_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ovr_idle_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge CLK);
    #1;

    // Underrun: short frame is zero-padded, then the next frame decodes.
    b = pix_q.size(); o0 = n_ovr; u0 = n_und; f0 = n_fd;
    send_run(1'b1, 1'b1, 10'd2);
    send_run(1'b1, 1'b0, 10'd7);
    idle_in();
    wait_cycles(14);
    check("und_count", pix_q.size() - b, 32'd16);
    check_frame("und_pad", b, 8'h07, 1'b0);
    check_frame("und_next", b + 8, 8'h00, 1'b0);
    check("und_pulses", n_und - u0, 32'd1);
    check("und_overrun", n_ovr - o0, 32'd0);
    check("und_frame_done", n_fd - f0, 32'd2);

    // Stray run with no frame open: consumed, flagged, no pixels.
    b = pix_q.size(); o0 = n_ovr;
    send_run(1'b0, 1'b1, 10'd3);
    idle_in();
    wait_cycles(4);
    check("stray_pixels", pix_q.size() - b, 32'd0);
    check("stray_overrun", n_ovr - o0, 32'd1);

    // Reset mid-frame, then a fresh frame 0,0,1,1,1,1,1,1.
    f0 = n_fd;
    send_run(1'b1, 1'b1, 10'd7);
    idle_in();
    wait_cycles(3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_eop", {31'd0, bus.out_eop}, 32'd0);
    @(posedge CLK);
    #1 reset_n = 1'b1;
    check("mid_rst_no_eop", n_fd - f0, 32'd0);
    b = pix_q.size(); f0 = n_fd;
    send_run(1'b1, 1'b0, 10'd1);
    send_run(1'b0, 1'b1, 10'd5);
    idle_in();
    wait_cycles(12);
    check("post_rst_count", pix_q.size() - b, 32'd8);
    check_frame("post_rst", b, 8'hFC, 1'b0);
    check("post_rst_frame_done", n_fd - f0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
